// File: rtl/key_pkg.sv
// Shared types and constants for the key event queue.
package key_pkg;

    // Auto-repeat controller states
    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rep_state_t;

    localparam int DEF_N_KEYS = 12;
    localparam int DEF_CODE_W = $clog2(DEF_N_KEYS);

    // Event entry layout: {repeat, code}
    localparam int CODE_OFS = 0;

    function automatic int entry_w(input int code_w);
        return code_w + 1;
    endfunction

    function automatic int repeat_ofs(input int code_w);
        return code_w;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single key line: two-flop synchroniser followed by a tick-sampled debouncer.
module key_debounce
    import key_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk_raw,
    input  logic rst,
    input  logic tick,
    input  logic key_raw,
    output logic key_stable
);

    localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous key line into the clk_raw domain
    always_ff @(posedge clk_raw) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= key_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Count consecutive differing samples; flip the stable level once enough agree
    always_ff @(posedge clk_raw) begin
        if (rst) begin
            cnt        <= '0;
            key_stable <= 1'b0;
        end else if (tick) begin
            if (sync_p1 != key_stable) begin
                if (cnt == CNT_W'(STABLE_SAMPLES - 1)) begin
                    key_stable <= ~key_stable;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Debounced key scanner producing press and auto-repeat events into a small FIFO.
module key_event_queue
    import key_pkg::*;
#(
    parameter  int N_KEYS          = DEF_N_KEYS,
    parameter  int DEBOUNCE_CYCLES = 100000,
    parameter  int STABLE_SAMPLES  = 4,
    parameter  int REPEAT_DELAY    = 50,
    parameter  int REPEAT_PERIOD   = 10,
    parameter  int FIFO_DEPTH      = 4,
    localparam int CODE_W          = $clog2(N_KEYS)
) (
    input  logic              clk_raw,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keystroke,
    output logic [N_KEYS-1:0] key_stable,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CODE_W-1:0] ev_code,
    output logic              ev_repeat,
    output logic              repeat_dropped
);

    localparam int TCNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W  = $clog2(RMAX + 1);
    localparam int ENTRY_W = entry_w(CODE_W);
    localparam int REP_OFS = repeat_ofs(CODE_W);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    logic [TCNT_W-1:0]  tcnt;
    logic               tick;
    logic [N_KEYS-1:0]  stable_prev;
    logic [N_KEYS-1:0]  pending;
    logic [N_KEYS-1:0]  press_mask;
    logic               press_any;
    logic [CODE_W-1:0]  press_code;
    logic               push_press;
    logic               push_rep;
    logic               push;
    logic               pop;
    logic               full;
    logic [ENTRY_W-1:0] push_entry;

    rep_state_t         state, state_n;
    logic [CODE_W-1:0]  held, held_n;
    logic [RCNT_W-1:0]  rcnt, rcnt_n;
    logic               repeat_req, req_n;
    logic               drop_n;
    logic               fire;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    assign tick = (tcnt == TCNT_W'(DEBOUNCE_CYCLES - 1));

    // Free-running sample tick shared by all debouncers and the repeat timer
    always_ff @(posedge clk_raw) begin
        if (rst) tcnt <= '0;
        else     tcnt <= tick ? '0 : tcnt + 1'b1;
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_deb (
            .clk_raw   (clk_raw),
            .rst       (rst),
            .tick      (tick),
            .key_raw   (keystroke[g]),
            .key_stable(key_stable[g])
        );
    end

    // Latch rising debounced edges as pending presses until the FIFO takes them
    always_ff @(posedge clk_raw) begin
        if (rst) begin
            stable_prev <= '0;
            pending     <= '0;
        end else begin
            stable_prev <= key_stable;
            pending     <= (pending | (key_stable & ~stable_prev)) & ~press_mask;
        end
    end

    // Pick the lowest-index pending press, else the repeat request
    always_comb begin
        press_any  = 1'b0;
        press_code = '0;
        press_mask = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                press_any  = 1'b1;
                press_code = CODE_W'(i);
                press_mask = '0;
                press_mask[i] = 1'b1;
            end
        end
        full       = (count == (PTR_W+1)'(FIFO_DEPTH));
        push_press = press_any && !full;
        push_rep   = !press_any && repeat_req && !full;
        push       = push_press || push_rep;
        push_entry = push_rep ? {1'b1, held} : {1'b0, press_code};
        if (!push_press) press_mask = '0;
        pop        = ev_valid && ev_ready;
    end

    // Repeat controller state register
    always_ff @(posedge clk_raw) begin
        if (rst) begin
            state          <= IDLE;
            held           <= '0;
            rcnt           <= '0;
            repeat_req     <= 1'b0;
            repeat_dropped <= 1'b0;
        end else begin
            state          <= state_n;
            held           <= held_n;
            rcnt           <= rcnt_n;
            repeat_req     <= req_n;
            repeat_dropped <= drop_n;
        end
    end

    // Repeat controller next state: a press restarts the delay for that key
    always_comb begin
        state_n = state;
        held_n  = held;
        rcnt_n  = rcnt;
        req_n   = repeat_req;
        drop_n  = repeat_dropped;
        fire    = 1'b0;
        if (push_rep) req_n = 1'b0;
        if (push_press) begin
            held_n  = press_code;
            rcnt_n  = '0;
            state_n = DELAY;
            // An outstanding repeat belongs to the previously held key
            req_n   = 1'b0;
        end else begin
            case (state)
                DELAY: begin
                    if (!key_stable[held]) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end else if (tick) begin
                        if (rcnt == RCNT_W'(REPEAT_DELAY - 1)) begin
                            fire    = 1'b1;
                            rcnt_n  = '0;
                            state_n = REPEAT;
                        end else begin
                            rcnt_n = rcnt + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (!key_stable[held]) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end else if (tick) begin
                        if (rcnt == RCNT_W'(REPEAT_PERIOD - 1)) begin
                            fire   = 1'b1;
                            rcnt_n = '0;
                        end else begin
                            rcnt_n = rcnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (fire) begin
                if (repeat_req && full) drop_n = 1'b1;
                req_n = 1'b1;
            end
        end
    end

    // Show-ahead event FIFO; a full FIFO refuses pushes even when popping
    always_ff @(posedge clk_raw) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign ev_valid  = (count != '0);
    assign ev_code   = mem[rd_ptr][CODE_OFS +: CODE_W];
    assign ev_repeat = mem[rd_ptr][REP_OFS];

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with small timing parameters.
module tb_key_event_queue;

    logic        clk_raw;
    logic        rst;
    logic [11:0] keystroke;
    logic [11:0] key_stable;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_code;
    logic        ev_repeat;
    logic        repeat_dropped;

    key_event_queue #(
        .N_KEYS         (12),
        .DEBOUNCE_CYCLES(4),
        .STABLE_SAMPLES (3),
        .REPEAT_DELAY   (5),
        .REPEAT_PERIOD  (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk_raw       (clk_raw),
        .rst           (rst),
        .keystroke     (keystroke),
        .key_stable    (key_stable),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_code       (ev_code),
        .ev_repeat     (ev_repeat),
        .repeat_dropped(repeat_dropped)
    );

    initial begin
        clk_raw = 1'b0;
        forever #5 clk_raw = ~clk_raw;
    end

    // Event log filled by the monitor, cleared while reset is asserted
    int cyc = 0;
    int ev_n = 0;
    int stable_cyc = -1;
    int ev_code_log [64];
    int ev_rep_log  [64];
    int ev_cyc_log  [64];

    always begin
        @(negedge clk_raw);
        #1;
        cyc++;
        if (rst) begin
            ev_n       = 0;
            stable_cyc = -1;
        end else begin
            if (stable_cyc < 0 && key_stable != 12'h000) stable_cyc = cyc;
            if (ev_valid && ev_ready && ev_n < 64) begin
                ev_code_log[ev_n] = int'(ev_code);
                ev_rep_log[ev_n]  = int'(ev_repeat);
                ev_cyc_log[ev_n]  = cyc;
                ev_n++;
            end
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [11:0] k);
        @(negedge clk_raw);
        rst       = 1'b1;
        keystroke = 12'h000;
        repeat (2) @(negedge clk_raw);
        rst       = 1'b0;
        keystroke = k;
    endtask

    typedef struct {
        string       name;
        logic [11:0] keys;
        int          hold;
        int          exp_events;
        int          exp_code;
        int          exp_reps;
        int          exp_stable;
    } vec_t;

    vec_t tbl [6];

    initial begin
        rst       = 1'b1;
        keystroke = 12'hFFF;
        ev_ready  = 1'b1;

        tbl[0] = '{"key1_press",   12'h002, 16, 1, 1,  0, 1};
        tbl[1] = '{"key7_glitch8", 12'h080,  8, 0, 0,  0, 0};
        tbl[2] = '{"key3_repeat",  12'h008, 47, 5, 3,  4, 1};
        tbl[3] = '{"key11_press",  12'h800, 16, 1, 11, 0, 1};
        tbl[4] = '{"key0_press",   12'h001, 16, 1, 0,  0, 1};
        tbl[5] = '{"key7_glitch9", 12'h080,  9, 0, 0,  0, 0};

        // Reset state with all raw lines high
        repeat (4) @(negedge clk_raw);
        chk("rst_key_stable", int'(key_stable), 0);
        chk("rst_ev_valid",   int'(ev_valid), 0);
        chk("rst_ev_code",    int'(ev_code), 0);
        chk("rst_ev_repeat",  int'(ev_repeat), 0);
        chk("rst_dropped",    int'(repeat_dropped), 0);

        // Table: single key held for a number of cycles, then released
        for (int r = 0; r < 6; r++) begin
            int reps;
            do_reset(tbl[r].keys);
            repeat (tbl[r].hold) @(negedge clk_raw);
            keystroke = 12'h000;
            repeat (80) @(negedge clk_raw);
            chk({tbl[r].name, "_events"}, ev_n, tbl[r].exp_events);
            chk({tbl[r].name, "_stable_seen"}, int'(stable_cyc >= 0), tbl[r].exp_stable);
            chk({tbl[r].name, "_stable_end"}, int'(key_stable), 0);
            chk({tbl[r].name, "_valid_end"}, int'(ev_valid), 0);
            if (tbl[r].exp_events > 0 && ev_n > 0) begin
                chk({tbl[r].name, "_latency"}, ev_cyc_log[0] - stable_cyc, 2);
                chk({tbl[r].name, "_first_rep"}, ev_rep_log[0], 0);
                reps = 0;
                for (int j = 0; j < ev_n; j++) begin
                    chk({tbl[r].name, "_code"}, ev_code_log[j], tbl[r].exp_code);
                    reps += ev_rep_log[j];
                end
                chk({tbl[r].name, "_repeats"}, reps, tbl[r].exp_reps);
                if (tbl[r].exp_reps >= 2 && ev_n >= 3) begin
                    chk({tbl[r].name, "_delay_gap"}, ev_cyc_log[1] - ev_cyc_log[0], 19);
                    chk({tbl[r].name, "_period_gap"}, ev_cyc_log[2] - ev_cyc_log[1], 8);
                end
            end
        end

        // Two keys rising together: lower code first, repeats follow the last press
        do_reset(12'h082);
        repeat (47) @(negedge clk_raw);
        keystroke = 12'h000;
        repeat (60) @(negedge clk_raw);
        chk("dual_events", ev_n, 6);
        if (ev_n >= 6) begin
            chk("dual_ev0_code", ev_code_log[0], 1);
            chk("dual_ev0_rep",  ev_rep_log[0], 0);
            chk("dual_ev1_code", ev_code_log[1], 7);
            chk("dual_ev1_rep",  ev_rep_log[1], 0);
            chk("dual_back2back", ev_cyc_log[1] - ev_cyc_log[0], 1);
            for (int j = 2; j < 6; j++) begin
                chk("dual_rep_code", ev_code_log[j], 7);
                chk("dual_rep_flag", ev_rep_log[j], 1);
            end
        end

        // Stalled consumer: FIFO fills, a repeat is dropped, a later press waits
        ev_ready = 1'b0;
        do_reset(12'h008);
        repeat (50) @(negedge clk_raw);
        chk("stall_dropped_early", int'(repeat_dropped), 0);
        chk("stall_head_valid", int'(ev_valid), 1);
        chk("stall_head_code",  int'(ev_code), 3);
        chk("stall_head_rep",   int'(ev_repeat), 0);
        keystroke = 12'h028;
        repeat (80) @(negedge clk_raw);
        chk("stall_dropped", int'(repeat_dropped), 1);
        chk("stall_no_pops", ev_n, 0);
        ev_ready  = 1'b1;
        keystroke = 12'h000;
        repeat (30) @(negedge clk_raw);
        chk("drain_min_events", int'(ev_n >= 5), 1);
        if (ev_n >= 5) begin
            chk("drain0_code", ev_code_log[0], 3);
            chk("drain0_rep",  ev_rep_log[0], 0);
            for (int j = 1; j < 4; j++) begin
                chk("drain_rep_code", ev_code_log[j], 3);
                chk("drain_rep_flag", ev_rep_log[j], 1);
            end
            chk("drain4_code", ev_code_log[4], 5);
            chk("drain4_rep",  ev_rep_log[4], 0);
            chk("drain_span",  ev_cyc_log[4] - ev_cyc_log[0], 4);
        end
        chk("drain_dropped_sticky", int'(repeat_dropped), 1);

        // Reset while repeating, key still held: everything clears, one fresh press follows
        do_reset(12'h008);
        repeat (40) @(negedge clk_raw);
        chk("midrst_pre_events", ev_n, 2);
        rst = 1'b1;
        @(negedge clk_raw);
        chk("midrst_key_stable", int'(key_stable), 0);
        chk("midrst_ev_valid",   int'(ev_valid), 0);
        chk("midrst_ev_code",    int'(ev_code), 0);
        chk("midrst_ev_repeat",  int'(ev_repeat), 0);
        chk("midrst_dropped",    int'(repeat_dropped), 0);
        rst = 1'b0;
        repeat (25) @(negedge clk_raw);
        chk("midrst_post_events", ev_n, 1);
        if (ev_n >= 1) begin
            chk("midrst_post_code", ev_code_log[0], 3);
            chk("midrst_post_rep",  ev_rep_log[0], 0);
            chk("midrst_post_latency", ev_cyc_log[0] - stable_cyc, 2);
        end
        keystroke = 12'h000;
        repeat (4) @(negedge clk_raw);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Parametrised successor to the raw keystroke input path of core.
- Synchronises and debounces N_KEYS raw key lines, and generates press events plus auto-repeat events for the most recently pressed key.
- Queues events in a small FIFO drained through a valid/ready handshake.
- Sits between the board key inputs and core's game/control logic, replacing direct sampling of keystroke.

Parameters:
- N_KEYS, 12: number of key lines.
- DEBOUNCE_CYCLES, 100000: clk_raw cycles per sample tick.
- STABLE_SAMPLES, 4: consecutive equal samples required to change a key's stable state.
- REPEAT_DELAY, 50: ticks from a press to the first repeat.
- REPEAT_PERIOD, 10: ticks between subsequent repeats.
- FIFO_DEPTH, 4: event FIFO entries, power of two, at least 2.
- CODE_W, $clog2(N_KEYS): key code width (derived).

Ports:
- clk_raw  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- keystroke  in  N_KEYS  raw key lines, active-high, asynchronous.
- key_stable  out  N_KEYS  debounced key levels.
- ev_valid  out  1  FIFO head valid.
- ev_ready  in  1  consumer accepts the head.
- ev_code  out  CODE_W  key index of the head event.
- ev_repeat  out  1  head event is a repeat (0 = press).
- repeat_dropped  out  1  sticky; a repeat event was lost because the FIFO was full.

Behaviour:
- Reset: one clock and a synchronous, active-high reset, both fixed. On rst:
  - key_stable=0, ev_valid=0, ev_code=0, ev_repeat=0, repeat_dropped=0.
  - Synchronisers, tick counter, sample counters, pending bits, FSM and FIFO are all cleared.
- Synchroniser: 2-flop per key line.
- Tick: counter 0..DEBOUNCE_CYCLES-1. The tick pulse lasts one cycle when the counter wraps.
- Debounce, per key, on each tick:
  - If the synchronised sample differs from key_stable[i], increment the key's counter; otherwise clear it.
  - When the counter reaches STABLE_SAMPLES, toggle key_stable[i] and clear the counter.
  - A glitch shorter than STABLE_SAMPLES ticks never changes key_stable.
- Press detect:
  - A rising key_stable[i], against the registered previous value, sets pending[i].
  - Falling edges generate no event.
- Arbiter, at most one FIFO push per cycle:
  - Priority: lowest-index pending press, then repeat_req.
  - Pushing a press clears its pending bit; press events are never lost, they wait while the FIFO is full.
  - Pushing a repeat clears repeat_req.
- Repeat FSM, states IDLE, DELAY, REPEAT; tick counter rcnt:
  - Any press push for key k: held=k, rcnt=0, go to DELAY. This holds from any state, so the last pushed press wins.
  - DELAY: on each tick rcnt++. At rcnt==REPEAT_DELAY-1 on a tick: set repeat_req, rcnt=0, go to REPEAT.
  - REPEAT: at rcnt==REPEAT_PERIOD-1 on a tick: set repeat_req, rcnt=0.
  - key_stable[held]==0 in DELAY or REPEAT: go to IDLE and clear repeat_req.
  - A new repeat request while repeat_req is still set coalesces into it.
  - A repeat request arriving while the FIFO is full and repeat_req is still set sets repeat_dropped.
- FIFO:
  - Entry is {repeat, code}; show-ahead.
  - ev_valid = not empty; ev_code/ev_repeat reflect the head.
  - Pop when ev_valid && ev_ready.
  - Full blocks push even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO keep the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: with the FIFO empty and no older pending press, ev_valid rises exactly 2 clk_raw cycles after key_stable[i] rises.
- Reset mid-operation: all state is lost. A key held through reset release is reported as a new press once it has been stable for STABLE_SAMPLES ticks.

Decomposition:
- Package key_pkg holds:
  - the repeat FSM enum (IDLE, DELAY, REPEAT);
  - the event entry width (CODE_W+1) and field offsets;
  - default N_KEYS.
- One natural sub-module: key_debounce, a single-key synchroniser plus sample counter, instantiated N_KEYS times via generate. It shares the tick from the parent.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, STABLE_SAMPLES=3, REPEAT_DELAY=5, REPEAT_PERIOD=2, FIFO_DEPTH=4; ev_ready=1 unless stated.
- keystroke=12'h002 held -> key_stable[1] rises after 3 ticks; exactly one event, code=1, repeat=0, ev_valid high 2 cycles after key_stable[1].
- keystroke[7] high for 2 ticks then low -> key_stable stays 0, no event.
- keystroke 12'h082 rising in the same cycle -> events code=1 then code=7 on consecutive cycles; later repeats carry code=7.
- keystroke=12'h008 held 11 ticks after the press, then released -> 1 press plus 4 repeats (ticks 5, 7, 9, 11), then no further events.
- ev_ready=0, key 3 held 30 ticks -> FIFO holds press plus 3 repeats and repeat_dropped=1. A key 5 press meanwhile stays pending; with ev_ready=1 the order drained is 4 queued entries, then code=5.
- rst pulsed during REPEAT -> next cycle all outputs 0 and the FIFO is empty. With the key still held, one new press event follows after 3 ticks.
